sys_ctrl: RTL and testbench

System-domain command controller sitting directly downstream of the RX data synchronizer. It consumes the byte stream delivered as a synchronized bus plus a one-cycle enable pulse, parses command frames, and drives register-file writes/reads and ALU operations. Responses are pushed into the TX FIFO, byte by byte, with full-flag backpressure.

---
 rtl/sys_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sys_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// System-domain command controller: parses RX command frames, drives register-file
// and ALU strobes, and streams responses into the TX FIFO with full-flag backpressure.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  output logic [ADDR_WIDTH-1:0]     rf_addr,
  output logic [DATA_WIDTH-1:0]     rf_wr_data,
  output logic                      rf_wr_en,
  output logic                      rf_rd_en,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data,
  input  logic                      rf_rd_valid,
  output logic [FUN_WIDTH-1:0]      alu_fun,
  output logic                      alu_en,
  output logic                      gate_en,
  input  logic [2*DATA_WIDTH-1:0]   alu_out,
  input  logic                      alu_out_valid,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_wr_en,
  input  logic                      tx_full,
  output logic                      frame_err
);

  localparam logic [DATA_WIDTH-1:0] OP_RF_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RF_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD,
    ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB
  } state_t;

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]     rd_q, rd_nxt;
  logic [2*DATA_WIDTH-1:0]   res_q, res_nxt;

  logic [ADDR_WIDTH-1:0]     rf_addr_nxt;
  logic [DATA_WIDTH-1:0]     rf_wr_data_nxt, tx_data_nxt;
  logic [FUN_WIDTH-1:0]      alu_fun_nxt;
  logic                      rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt;
  logic                      gate_en_nxt, tx_wr_en_nxt, frame_err_nxt;

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr_q;
    rd_nxt         = rd_q;
    res_nxt        = res_q;
    rf_addr_nxt    = rf_addr;
    rf_wr_data_nxt = rf_wr_data;
    alu_fun_nxt    = alu_fun;
    tx_data_nxt    = tx_data;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    alu_en_nxt     = 1'b0;
    tx_wr_en_nxt   = 1'b0;
    frame_err_nxt  = 1'b0;

    case (state)
      IDLE: if (rx_valid) begin
        case (rx_data)
          OP_RF_WR:  state_nxt = WR_ADDR;
          OP_RF_RD:  state_nxt = RD_ADDR;
          OP_ALU_OP: state_nxt = ALU_A;
          OP_ALU_NO: state_nxt = ALU_FUN;
          default:   frame_err_nxt = 1'b1;
        endcase
      end
      WR_ADDR: if (rx_valid) begin
        addr_nxt  = rx_data[ADDR_WIDTH-1:0];
        state_nxt = WR_DATA;
      end
      WR_DATA: if (rx_valid) begin
        rf_wr_en_nxt   = 1'b1;
        rf_addr_nxt    = addr_q;
        rf_wr_data_nxt = rx_data;
        state_nxt      = IDLE;
      end
      RD_ADDR: if (rx_valid) begin
        rf_rd_en_nxt = 1'b1;
        rf_addr_nxt  = rx_data[ADDR_WIDTH-1:0];
        state_nxt    = RD_WAIT;
      end
      ALU_A: if (rx_valid) begin
        rf_wr_en_nxt   = 1'b1;
        rf_addr_nxt    = '0;
        rf_wr_data_nxt = rx_data;
        state_nxt      = ALU_B;
      end
      ALU_B: if (rx_valid) begin
        rf_wr_en_nxt   = 1'b1;
        rf_addr_nxt    = ADDR_WIDTH'(1);
        rf_wr_data_nxt = rx_data;
        state_nxt      = ALU_FUN;
      end
      ALU_FUN: if (rx_valid) begin
        alu_en_nxt  = 1'b1;
        alu_fun_nxt = rx_data[FUN_WIDTH-1:0];
        state_nxt   = ALU_WAIT;
      end
      // Response-phase states: a stray RX byte is dropped and flagged, while
      // the pending read/ALU/TX handshake carries on independently.
      RD_WAIT: begin
        frame_err_nxt = rx_valid;
        if (rf_rd_valid) begin
          rd_nxt    = rf_rd_data;
          state_nxt = TX_RD;
        end
      end
      TX_RD: begin
        frame_err_nxt = rx_valid;
        if (!tx_full) begin
          tx_wr_en_nxt = 1'b1;
          tx_data_nxt  = rd_q;
          state_nxt    = IDLE;
        end
      end
      ALU_WAIT: begin
        frame_err_nxt = rx_valid;
        if (alu_out_valid) begin
          res_nxt   = alu_out;
          state_nxt = TX_LSB;
        end
      end
      TX_LSB: begin
        frame_err_nxt = rx_valid;
        if (!tx_full) begin
          tx_wr_en_nxt = 1'b1;
          tx_data_nxt  = res_q[DATA_WIDTH-1:0];
          state_nxt    = TX_MSB;
        end
      end
      TX_MSB: begin
        frame_err_nxt = rx_valid;
        if (!tx_full) begin
          tx_wr_en_nxt = 1'b1;
          tx_data_nxt  = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Registered from the next state so gate_en tracks ALU_FUN/ALU_WAIT exactly.
    gate_en_nxt = (state_nxt == ALU_FUN) || (state_nxt == ALU_WAIT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      addr_q     <= '0;
      rd_q       <= '0;
      res_q      <= '0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      alu_fun    <= '0;
      alu_en     <= 1'b0;
      gate_en    <= 1'b0;
      tx_data    <= '0;
      tx_wr_en   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_q     <= addr_nxt;
      rd_q       <= rd_nxt;
      res_q      <= res_nxt;
      rf_addr    <= rf_addr_nxt;
      rf_wr_data <= rf_wr_data_nxt;
      rf_wr_en   <= rf_wr_en_nxt;
      rf_rd_en   <= rf_rd_en_nxt;
      alu_fun    <= alu_fun_nxt;
      alu_en     <= alu_en_nxt;
      gate_en    <= gate_en_nxt;
      tx_data    <= tx_data_nxt;
      tx_wr_en   <= tx_wr_en_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed table-driven bench for sys_ctrl: one row per clock cycle of inputs with
// the registered outputs expected just after that cycle's rising edge.
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wr_data;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic        gate_en;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        tx_full;
  logic        frame_err;

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_fun(alu_fun), .alu_en(alu_en), .gate_en(gate_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full),
    .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rv;
    logic [7:0]  rd;
    logic        rrv;
    logic [7:0]  rrd;
    logic        av;
    logic [15:0] ao;
    logic        full;
  } in_t;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [7:0]  wd;
    logic        ae;
    logic [3:0]  fun;
    logic        gate;
    logic        tw;
    logic [7:0]  td;
    logic        fe;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic in_t mi(input logic rv, input logic [7:0] rd, input logic rrv,
                             input logic [7:0] rrd, input logic av, input logic [15:0] ao,
                             input logic full);
    return '{rv: rv, rd: rd, rrv: rrv, rrd: rrd, av: av, ao: ao, full: full};
  endfunction

  function automatic in_t rx(input logic [7:0] d);
    return mi(1'b1, d, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
  endfunction

  function automatic in_t idle();
    return mi(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
  endfunction

  function automatic out_t mo(input logic we, input logic re, input logic [3:0] addr,
                              input logic [7:0] wd, input logic ae, input logic [3:0] fun,
                              input logic gate, input logic tw, input logic [7:0] td,
                              input logic fe);
    return '{we: we, re: re, addr: addr, wd: wd, ae: ae, fun: fun,
             gate: gate, tw: tw, td: td, fe: fe};
  endfunction

  function automatic void add(input string name, input in_t in, input out_t exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    tbl.push_back(v);
  endfunction

  task automatic apply(input in_t in);
    rx_valid      = in.rv;
    rx_data       = in.rd;
    rf_rd_valid   = in.rrv;
    rf_rd_data    = in.rrd;
    alu_out_valid = in.av;
    alu_out       = in.ao;
    tx_full       = in.full;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
           gate_en, tx_wr_en, tx_data, frame_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got we=%b re=%b addr=%h wd=%h ae=%b fun=%h gate=%b tw=%b td=%h fe=%b, want we=%b re=%b addr=%h wd=%h ae=%b fun=%h gate=%b tw=%b td=%h fe=%b",
               name, act.we, act.re, act.addr, act.wd, act.ae, act.fun, act.gate, act.tw, act.td, act.fe,
               exp.we, exp.re, exp.addr, exp.wd, exp.ae, exp.fun, exp.gate, exp.tw, exp.td, exp.fe);
    end
  endtask

  task automatic step(input string name, input in_t in, input out_t exp);
    apply(in);
    @(posedge CLK);
    #1;
    check(name, exp);
  endtask

  initial begin
    // RF write frame
    add("wr_op",    rx(8'hAA), mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    add("wr_addr",  rx(8'h05), mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    add("wr_data",  rx(8'h3C), mo(1,0,4'h5,8'h3C,0,4'h0,0,0,8'h00,0));
    add("wr_done",  idle(),    mo(0,0,4'h5,8'h3C,0,4'h0,0,0,8'h00,0));
    // RF read frame
    add("rd_op",    rx(8'hBB), mo(0,0,4'h5,8'h3C,0,4'h0,0,0,8'h00,0));
    add("rd_addr",  rx(8'h07), mo(0,1,4'h7,8'h3C,0,4'h0,0,0,8'h00,0));
    add("rd_wait",  idle(),    mo(0,0,4'h7,8'h3C,0,4'h0,0,0,8'h00,0));
    add("rd_valid", mi(0,8'h00,1,8'h9E,0,16'h0,0), mo(0,0,4'h7,8'h3C,0,4'h0,0,0,8'h00,0));
    add("rd_tx",    idle(),    mo(0,0,4'h7,8'h3C,0,4'h0,0,1,8'h9E,0));
    add("rd_done",  idle(),    mo(0,0,4'h7,8'h3C,0,4'h0,0,0,8'h9E,0));
    // ALU with operands
    add("cc_op",    rx(8'hCC), mo(0,0,4'h7,8'h3C,0,4'h0,0,0,8'h9E,0));
    add("cc_a",     rx(8'h10), mo(1,0,4'h0,8'h10,0,4'h0,0,0,8'h9E,0));
    add("cc_b",     rx(8'h20), mo(1,0,4'h1,8'h20,0,4'h0,1,0,8'h9E,0));
    add("cc_fun",   rx(8'h02), mo(0,0,4'h1,8'h20,1,4'h2,1,0,8'h9E,0));
    add("cc_wait",  idle(),    mo(0,0,4'h1,8'h20,0,4'h2,1,0,8'h9E,0));
    add("cc_res",   mi(0,8'h00,0,8'h00,1,16'h0200,0), mo(0,0,4'h1,8'h20,0,4'h2,0,0,8'h9E,0));
    add("cc_lsb",   idle(),    mo(0,0,4'h1,8'h20,0,4'h2,0,1,8'h00,0));
    add("cc_msb",   idle(),    mo(0,0,4'h1,8'h20,0,4'h2,0,1,8'h02,0));
    add("cc_done",  idle(),    mo(0,0,4'h1,8'h20,0,4'h2,0,0,8'h02,0));
    // ALU without operands, TX backpressure
    add("dd_op",    rx(8'hDD), mo(0,0,4'h1,8'h20,0,4'h2,1,0,8'h02,0));
    add("dd_fun",   rx(8'h01), mo(0,0,4'h1,8'h20,1,4'h1,1,0,8'h02,0));
    add("dd_res",   mi(0,8'h00,0,8'h00,1,16'h1234,1), mo(0,0,4'h1,8'h20,0,4'h1,0,0,8'h02,0));
    for (int k = 0; k < 5; k++)
      add("dd_full", mi(0,8'h00,0,8'h00,0,16'h0,1), mo(0,0,4'h1,8'h20,0,4'h1,0,0,8'h02,0));
    add("dd_lsb",   idle(),    mo(0,0,4'h1,8'h20,0,4'h1,0,1,8'h34,0));
    add("dd_msb",   idle(),    mo(0,0,4'h1,8'h20,0,4'h1,0,1,8'h12,0));
    add("dd_done",  idle(),    mo(0,0,4'h1,8'h20,0,4'h1,0,0,8'h12,0));
    // Frame errors
    add("bad_op",   rx(8'h55), mo(0,0,4'h1,8'h20,0,4'h1,0,0,8'h12,1));
    add("bad_clr",  idle(),    mo(0,0,4'h1,8'h20,0,4'h1,0,0,8'h12,0));
    add("e_op",     rx(8'hDD), mo(0,0,4'h1,8'h20,0,4'h1,1,0,8'h12,0));
    add("e_fun",    rx(8'h03), mo(0,0,4'h1,8'h20,1,4'h3,1,0,8'h12,0));
    add("e_drop",   rx(8'h77), mo(0,0,4'h1,8'h20,0,4'h3,1,0,8'h12,1));
    add("e_res",    mi(0,8'h00,0,8'h00,1,16'hABCD,0), mo(0,0,4'h1,8'h20,0,4'h3,0,0,8'h12,0));
    add("e_lsb",    idle(),    mo(0,0,4'h1,8'h20,0,4'h3,0,1,8'hCD,0));
    add("e_msb",    idle(),    mo(0,0,4'h1,8'h20,0,4'h3,0,1,8'hAB,0));
    add("stray_vld", mi(0,8'h00,1,8'h11,1,16'hFFFF,0), mo(0,0,4'h1,8'h20,0,4'h3,0,0,8'hAB,0));
    add("ok_op",    rx(8'hAA), mo(0,0,4'h1,8'h20,0,4'h3,0,0,8'hAB,0));
    add("ok_addr",  rx(8'h0F), mo(0,0,4'h1,8'h20,0,4'h3,0,0,8'hAB,0));
    add("ok_data",  rx(8'hA5), mo(1,0,4'hF,8'hA5,0,4'h3,0,0,8'hAB,0));
    add("ok_done",  idle(),    mo(0,0,4'hF,8'hA5,0,4'h3,0,0,8'hAB,0));
    // Read response held by a full FIFO
    add("rf_op",    rx(8'hBB), mo(0,0,4'hF,8'hA5,0,4'h3,0,0,8'hAB,0));
    add("rf_addr",  rx(8'h02), mo(0,1,4'h2,8'hA5,0,4'h3,0,0,8'hAB,0));
    add("rf_vfull", mi(0,8'h00,1,8'h44,0,16'h0,1), mo(0,0,4'h2,8'hA5,0,4'h3,0,0,8'hAB,0));
    add("rf_full",  mi(0,8'h00,0,8'h00,0,16'h0,1), mo(0,0,4'h2,8'hA5,0,4'h3,0,0,8'hAB,0));
    add("rf_tx",    idle(),    mo(0,0,4'h2,8'hA5,0,4'h3,0,1,8'h44,0));
    add("rf_done",  idle(),    mo(0,0,4'h2,8'hA5,0,4'h3,0,0,8'h44,0));

    apply(idle());
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    #2 RST = 1'b1;
    step("post_reset", idle(), mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Asynchronous reset while waiting on the ALU
    step("r_op",   rx(8'hDD), mo(0,0,4'h2,8'hA5,0,4'h3,1,0,8'h44,0));
    step("r_fun",  rx(8'h06), mo(0,0,4'h2,8'hA5,1,4'h6,1,0,8'h44,0));
    step("r_wait", idle(),    mo(0,0,4'h2,8'hA5,0,4'h6,1,0,8'h44,0));
    #2 RST = 1'b0;
    #1 check("r_async", mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    #2 RST = 1'b1;
    step("r_late_alu", mi(0,8'h00,0,8'h00,1,16'h5555,0), mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    step("r_idle1",    idle(), mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    step("r_idle2",    idle(), mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    step("r_wr_op",    rx(8'hAA), mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    step("r_wr_addr",  rx(8'h02), mo(0,0,4'h0,8'h00,0,4'h0,0,0,8'h00,0));
    step("r_wr_data",  rx(8'h77), mo(1,0,4'h2,8'h77,0,4'h0,0,0,8'h00,0));
    step("r_wr_done",  idle(),    mo(0,0,4'h2,8'h77,0,4'h0,0,0,8'h00,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
